// File: rtl/id_ex_if.sv
// ID/EX stage bus: decode-side inputs, execute-side registered outputs, and the
// stall/flush/hazard control lines. The master drives the ID side, the slave is the stage.
interface id_ex_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int WB_W    = 2,
    parameter int M_W     = 2,
    parameter int EX_W    = 4
);
    logic               stall;
    logic               flush;
    logic               valid_in;
    logic [WB_W-1:0]    wb_in;
    logic [M_W-1:0]     m_in;
    logic [EX_W-1:0]    ex_in;
    logic [DATA_W-1:0]  rdata1_in;
    logic [DATA_W-1:0]  rdata2_in;
    logic [DATA_W-1:0]  imm_in;
    logic [RADDR_W-1:0] rs_in;
    logic [RADDR_W-1:0] rt_in;
    logic [RADDR_W-1:0] rd_in;

    logic               valid_out;
    logic [WB_W-1:0]    wb_out;
    logic [M_W-1:0]     m_out;
    logic [EX_W-1:0]    ex_out;
    logic [DATA_W-1:0]  rdata1_out;
    logic [DATA_W-1:0]  rdata2_out;
    logic [DATA_W-1:0]  imm_out;
    logic [RADDR_W-1:0] rs_out;
    logic [RADDR_W-1:0] rt_out;
    logic [RADDR_W-1:0] rd_out;
    logic [RADDR_W-1:0] shamt_out;
    logic               hazard_stall;

    modport master (
        output stall, flush, valid_in, wb_in, m_in, ex_in,
               rdata1_in, rdata2_in, imm_in, rs_in, rt_in, rd_in,
        input  valid_out, wb_out, m_out, ex_out, rdata1_out, rdata2_out,
               imm_out, rs_out, rt_out, rd_out, shamt_out, hazard_stall
    );

    modport slave (
        input  stall, flush, valid_in, wb_in, m_in, ex_in,
               rdata1_in, rdata2_in, imm_in, rs_in, rt_in, rd_in,
        output valid_out, wb_out, m_out, ex_out, rdata1_out, rdata2_out,
               imm_out, rs_out, rt_out, rd_out, shamt_out, hazard_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid bit, hold, flush and load-use bubble insertion.
// Optional ID_EX_PERF_CNT_EN adds saturating bubble_cnt / flush_cnt outputs.
module id_ex_stage #(
    parameter int               DATA_W      = 32,
    parameter int               RADDR_W     = 5,
    parameter int               WB_W        = 2,
    parameter int               M_W         = 2,
    parameter int               EX_W        = 4,
    parameter logic [WB_W-1:0]  WB_BUBBLE   = 2'b01,
    parameter int               MEMREAD_BIT = 1,
    parameter int               SHAMT_LSB   = 6
) (
    input  logic        clk,
    input  logic        reset,
    id_ex_if.slave      bus
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0] bubble_cnt,
    output logic [31:0] flush_cnt
`endif
);

    logic               valid_q,  valid_d;
    logic [WB_W-1:0]    wb_q,     wb_d;
    logic [M_W-1:0]     m_q,      m_d;
    logic [EX_W-1:0]    ex_q,     ex_d;
    logic [DATA_W-1:0]  rdata1_q, rdata1_d;
    logic [DATA_W-1:0]  rdata2_q, rdata2_d;
    logic [DATA_W-1:0]  imm_q,    imm_d;
    logic [RADDR_W-1:0] rs_q,     rs_d;
    logic [RADDR_W-1:0] rt_q,     rt_d;
    logic [RADDR_W-1:0] rd_q,     rd_d;
    logic [RADDR_W-1:0] shamt_q,  shamt_d;

    logic hazard;
    logic bubble;
    logic hold;

    // Hold semantics: stall (from downstream) freezes this stage; hazard_stall
    // (to upstream) asks PC and IF/ID to keep presenting the same ID instruction.
    assign hazard = valid_q & m_q[MEMREAD_BIT] & bus.valid_in & (rt_q != '0)
                  & ((rt_q == bus.rs_in) | (rt_q == bus.rt_in));

    assign bubble = reset | bus.flush | (~bus.stall & hazard);
    assign hold   = ~reset & ~bus.flush & bus.stall;

    always_comb begin
        valid_d  = valid_q;
        wb_d     = wb_q;
        m_d      = m_q;
        ex_d     = ex_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        imm_d    = imm_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        shamt_d  = shamt_q;
        if (bubble) begin
            valid_d  = 1'b0;
            wb_d     = WB_BUBBLE;
            m_d      = '0;
            ex_d     = '0;
            rdata1_d = '0;
            rdata2_d = '0;
            imm_d    = '0;
            rs_d     = '0;
            rt_d     = '0;
            rd_d     = '0;
            shamt_d  = '0;
        end else if (!hold) begin
            valid_d  = bus.valid_in;
            wb_d     = bus.wb_in;
            m_d      = bus.m_in;
            ex_d     = bus.ex_in;
            rdata1_d = bus.rdata1_in;
            rdata2_d = bus.rdata2_in;
            imm_d    = bus.imm_in;
            rs_d     = bus.rs_in;
            rt_d     = bus.rt_in;
            rd_d     = bus.rd_in;
            shamt_d  = bus.imm_in[SHAMT_LSB +: RADDR_W];
        end
    end

    always_ff @(posedge clk) begin
        valid_q  <= valid_d;
        wb_q     <= wb_d;
        m_q      <= m_d;
        ex_q     <= ex_d;
        rdata1_q <= rdata1_d;
        rdata2_q <= rdata2_d;
        imm_q    <= imm_d;
        rs_q     <= rs_d;
        rt_q     <= rt_d;
        rd_q     <= rd_d;
        shamt_q  <= shamt_d;
    end

    assign bus.valid_out    = valid_q;
    assign bus.wb_out       = wb_q;
    assign bus.m_out        = m_q;
    assign bus.ex_out       = ex_q;
    assign bus.rdata1_out   = rdata1_q;
    assign bus.rdata2_out   = rdata2_q;
    assign bus.imm_out      = imm_q;
    assign bus.rs_out       = rs_q;
    assign bus.rt_out       = rt_q;
    assign bus.rd_out       = rd_q;
    assign bus.shamt_out    = shamt_q;
    assign bus.hazard_stall = hazard;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] flush_cnt_q,  flush_cnt_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (reset) begin
            bubble_cnt_d = '0;
            flush_cnt_d  = '0;
        end else begin
            if (hazard && !bus.flush && !bus.stall && bubble_cnt_q != 32'hFFFF_FFFF)
                bubble_cnt_d = bubble_cnt_q + 32'd1;
            if (bus.flush && flush_cnt_q != 32'hFFFF_FFFF)
                flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        bubble_cnt_q <= bubble_cnt_d;
        flush_cnt_q  <= flush_cnt_d;
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: behavioural model of the stage checked every cycle,
// plus directed literal checks for reset, load, load-use, stall/flush and counters.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int RW     = 5;

    logic clk;
    logic reset;

    id_ex_if #(.DATA_W(DATA_W), .RADDR_W(RW)) bus ();

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt;
    logic [31:0] flush_cnt;
`endif

    id_ex_stage dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        valid;
        logic [1:0]  wb;
        logic [1:0]  m;
        logic [3:0]  ex;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
    } ex_slot_t;

    ex_slot_t mdl;
    bit       started = 0;
    logic [31:0] mdl_bub_cnt = 0;
    logic [31:0] mdl_flu_cnt = 0;

    function automatic ex_slot_t bubble_slot();
        ex_slot_t s;
        s.valid = 0; s.wb = 2'b01; s.m = 0; s.ex = 0;
        s.rd1 = 0; s.rd2 = 0; s.imm = 0; s.rs = 0; s.rt = 0; s.rd = 0; s.shamt = 0;
        return s;
    endfunction

    // Load-use: the instruction in EX is a load whose destination rt is read in ID.
    function automatic logic model_hazard();
        return mdl.valid && mdl.m[1] && bus.valid_in && (mdl.rt != 0)
            && ((mdl.rt == bus.rs_in) || (mdl.rt == bus.rt_in));
    endfunction

    always @(posedge clk) begin
        logic hz;
        hz = model_hazard();
        if (reset) begin
            mdl = bubble_slot();
            mdl_bub_cnt = 0;
            mdl_flu_cnt = 0;
        end else begin
            if (bus.flush && mdl_flu_cnt != 32'hFFFF_FFFF) mdl_flu_cnt++;
            if (hz && !bus.flush && !bus.stall && mdl_bub_cnt != 32'hFFFF_FFFF) mdl_bub_cnt++;
            if (bus.flush) mdl = bubble_slot();
            else if (bus.stall) mdl = mdl;
            else if (hz) mdl = bubble_slot();
            else begin
                mdl.valid = bus.valid_in;  mdl.wb  = bus.wb_in;    mdl.m   = bus.m_in;
                mdl.ex    = bus.ex_in;     mdl.rd1 = bus.rdata1_in; mdl.rd2 = bus.rdata2_in;
                mdl.imm   = bus.imm_in;    mdl.rs  = bus.rs_in;    mdl.rt  = bus.rt_in;
                mdl.rd    = bus.rd_in;     mdl.shamt = 5'((bus.imm_in >> 6) & 32'h1F);
            end
        end
        started = 1;
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("valid_out",  64'(bus.valid_out),  64'(mdl.valid));
            chk("wb_out",     64'(bus.wb_out),     64'(mdl.wb));
            chk("m_out",      64'(bus.m_out),      64'(mdl.m));
            chk("ex_out",     64'(bus.ex_out),     64'(mdl.ex));
            chk("rdata1_out", 64'(bus.rdata1_out), 64'(mdl.rd1));
            chk("rdata2_out", 64'(bus.rdata2_out), 64'(mdl.rd2));
            chk("imm_out",    64'(bus.imm_out),    64'(mdl.imm));
            chk("rs_out",     64'(bus.rs_out),     64'(mdl.rs));
            chk("rt_out",     64'(bus.rt_out),     64'(mdl.rt));
            chk("rd_out",     64'(bus.rd_out),     64'(mdl.rd));
            chk("shamt_out",  64'(bus.shamt_out),  64'(mdl.shamt));
            chk("hazard_stall", 64'(bus.hazard_stall), 64'(model_hazard()));
`ifdef ID_EX_PERF_CNT_EN
            chk("bubble_cnt", 64'(bubble_cnt), 64'(mdl_bub_cnt));
            chk("flush_cnt",  64'(flush_cnt),  64'(mdl_flu_cnt));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [31:0] rd1, input logic [31:0] imm);
        bus.valid_in  = v;
        bus.wb_in     = 2'b10;
        bus.m_in      = m;
        bus.ex_in     = 4'h3;
        bus.rdata1_in = rd1;
        bus.rdata2_in = 32'h0BAD_F00D;
        bus.imm_in    = imm;
        bus.rs_in     = rs;
        bus.rt_in     = rt;
        bus.rd_in     = 5'd17;
    endtask

    task automatic drive_random();
        bus.valid_in  = 1'($urandom_range(0, 3) != 0);
        bus.wb_in     = 2'($urandom);
        bus.m_in      = 2'($urandom);
        bus.ex_in     = 4'($urandom);
        bus.rdata1_in = $urandom;
        bus.rdata2_in = $urandom;
        bus.imm_in    = $urandom;
        bus.rs_in     = 5'($urandom_range(0, 3));
        bus.rt_in     = 5'($urandom_range(0, 3));
        bus.rd_in     = 5'($urandom);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        reset = 1'b1;
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        drive(1'b1, 2'b11, 5'd9, 5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        tick();
        chk("rst valid_out", 64'(bus.valid_out), 64'd0);
        chk("rst wb_out",    64'(bus.wb_out),    64'd1);
        chk("rst m_out",     64'(bus.m_out),     64'd0);
        chk("rst rdata1",    64'(bus.rdata1_out), 64'd0);
        chk("rst shamt",     64'(bus.shamt_out), 64'd0);
        chk("rst hazard",    64'(bus.hazard_stall), 64'd0);

        reset = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;

`ifdef ID_EX_PERF_CNT_EN
        drive(1'b1, 2'b10, 5'd1, 5'd8, 32'h1, 32'h0);   // lw -> $8
        tick();
        drive(1'b1, 2'b10, 5'd8, 5'd8, 32'h2, 32'h0);   // lw reading $8: hazard #1
        tick();
        tick();                                          // held lw loads
        drive(1'b1, 2'b00, 5'd8, 5'd2, 32'h3, 32'h0);   // hazard #2
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("perf bubble_cnt", 64'(bubble_cnt), 64'd2);
        chk("perf flush_cnt",  64'(flush_cnt),  64'd1);
        drive(1'b1, 2'b10, 5'd1, 5'd8, 32'h1, 32'h0);
        tick();
        drive(1'b1, 2'b00, 5'd8, 5'd2, 32'h3, 32'h0);
        force dut.bubble_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.bubble_cnt_q;
        mdl_bub_cnt = 32'hFFFF_FFFF;
        tick();
        chk("perf bubble_cnt sat", 64'(bubble_cnt), 64'hFFFF_FFFF);
        tick();
`endif

        // plain load
        drive(1'b1, 2'b00, 5'd4, 5'd5, 32'hDEAD_BEEF, 32'h0000_07C0);
        tick();
        chk("load rdata1", 64'(bus.rdata1_out), 64'hDEAD_BEEF);
        chk("load shamt",  64'(bus.shamt_out),  64'd31);
        chk("load valid",  64'(bus.valid_out),  64'd1);

        // load-use via rs
        drive(1'b1, 2'b10, 5'd1, 5'd8, 32'h11, 32'h0);
        tick();
        drive(1'b1, 2'b00, 5'd8, 5'd3, 32'h22, 32'h0);
        #1;
        chk("lu rs hazard", 64'(bus.hazard_stall), 64'd1);
        tick();
        chk("lu bubble valid", 64'(bus.valid_out), 64'd0);
        chk("lu bubble m",     64'(bus.m_out),     64'd0);
        chk("lu hazard drop",  64'(bus.hazard_stall), 64'd0);
        tick();
        chk("lu reload valid", 64'(bus.valid_out),  64'd1);
        chk("lu reload rs",    64'(bus.rs_out),     64'd8);
        chk("lu reload rd1",   64'(bus.rdata1_out), 64'h22);

        // rt_out = 0 never hazards
        drive(1'b1, 2'b10, 5'd1, 5'd0, 32'h33, 32'h0);
        tick();
        drive(1'b1, 2'b00, 5'd0, 5'd4, 32'h44, 32'h0);
        #1;
        chk("lu zero reg", 64'(bus.hazard_stall), 64'd0);

        // load-use via rt
        drive(1'b1, 2'b10, 5'd1, 5'd8, 32'h55, 32'h0);
        tick();
        drive(1'b1, 2'b00, 5'd1, 5'd8, 32'h66, 32'h0);
        #1;
        chk("lu rt hazard", 64'(bus.hazard_stall), 64'd1);
        tick();
        tick();

        // stall with changing inputs, then stall + flush
        drive(1'b1, 2'b00, 5'd2, 5'd3, 32'h1234_5678, 32'h0);
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            bus.m_in = 2'b00;
            tick();
            chk("stall hold rdata1", 64'(bus.rdata1_out), 64'h1234_5678);
            chk("stall hold valid",  64'(bus.valid_out),  64'd1);
        end
        bus.flush = 1'b1;
        tick();
        chk("stall+flush valid", 64'(bus.valid_out),  64'd0);
        chk("stall+flush wb",    64'(bus.wb_out),     64'd1);
        chk("stall+flush rd1",   64'(bus.rdata1_out), 64'd0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive_random();
            bus.stall = 1'($urandom_range(0, 5) == 0);
            bus.flush = 1'($urandom_range(0, 9) == 0);
            reset     = 1'($urandom_range(0, 49) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Parametrised ID/EX pipeline stage for the MIPS pipeline CPU. It registers the decode-stage control bundles (WB/M/EX), operands, the sign-extended immediate, and the register specifiers, and derives the shift amount from the immediate. Compared with a plain pipeline register, it adds:
- a valid bit;
- a hold path for downstream stalls;
- a flush path for branch/jump squash;
- built-in load-use hazard detection that inserts a bubble and requests an upstream stall.

It sits between the decode stage and the execute stage.

## Interface
Parameters:
- DATA_W, 32, operand/immediate width
- RADDR_W, 5, register specifier width
- WB_W, 2, WB control bundle width
- M_W, 2, M control bundle width
- EX_W, 4, EX control bundle width
- WB_BUBBLE, 2'b01, WB value loaded on reset/bubble/flush
- MEMREAD_BIT, 1, index of the MemRead bit inside M
- SHAMT_LSB, 6, LSB of the shamt field within the immediate (field width = RADDR_W)

Ports (reset is synchronous and active-high; clock is clk):
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- stall  in  1  downstream hold; stage keeps its contents
- flush  in  1  squash; stage loads a bubble
- valid_in  in  1  ID slot holds a real instruction
- wb_in / m_in / ex_in  in  WB_W / M_W / EX_W  control bundles
- rdata1_in, rdata2_in, imm_in  in  DATA_W each  operands and sign-extended immediate
- rs_in, rt_in, rd_in  in  RADDR_W each  register specifiers
- valid_out  out  1  EX slot holds a real instruction
- wb_out / m_out / ex_out  out  WB_W / M_W / EX_W  registered control bundles
- rdata1_out, rdata2_out, imm_out  out  DATA_W each  registered operands and immediate
- rs_out, rt_out, rd_out, shamt_out  out  RADDR_W each  registered specifiers and shift amount
- hazard_stall  out  1  combinational load-use stall request to PC and IF/ID

## Operation
- Load-use hazard:
  - hazard_stall = valid_out & m_out[MEMREAD_BIT] & valid_in & (rt_out != 0) & ((rt_out == rs_in) | (rt_out == rt_in)).
- Next-state priority, evaluated per clock edge:
  1. reset: bubble.
  2. flush: bubble.
  3. stall: hold every register unchanged.
  4. hazard_stall: bubble. Upstream holds the ID instruction for one cycle.
  5. Otherwise load: all *_out registers take their *_in values, valid_out takes valid_in, and shamt_out takes imm_in[SHAMT_LSB+RADDR_W-1:SHAMT_LSB].
- Bubble contents:
  - valid_out = 0
  - wb_out = WB_BUBBLE
  - m_out = 0, ex_out = 0
  - every data and specifier output = 0, including shamt_out
- When valid_in = 0 under a normal load, the bundles are still loaded as presented. The decoder guarantees zero control for invalid slots.
- Flush during stall: flush wins and the stage bubbles.
- Hazard during stall: the stage holds, and hazard_stall is still asserted, so upstream also holds.

## Timing
- Latency is 1 cycle from ID inputs to EX outputs.
- Reset value of every output, across the whole bubble set:
  - valid_out = 0
  - wb_out = WB_BUBBLE
  - all other registered outputs = 0
- hazard_stall is purely combinational from the current outputs and rs_in/rt_in. It has no register stage, and it is 0 during reset because valid_out is 0 after the first reset edge.
- A load-use pair costs exactly one bubble cycle:
  - On the hazard edge, EX receives a bubble. valid_out = 0 then drops hazard_stall.
  - The held ID instruction loads on the next edge.
- Reset mid-stall or mid-hazard: bubble on the next edge. No state survives.

## Configuration
- ID_EX_PERF_CNT_EN defined adds two outputs, each with the same reset and clear behaviour:
  - bubble_cnt: 32-bit, saturating; counts edges on which a hazard bubble is inserted (hazard_stall & ~flush & ~stall & ~reset).
  - flush_cnt: 32-bit, saturating; counts edges with flush & ~reset.
  - Both reset to 0 and saturate at 32'hFFFFFFFF.
- Undefined: the counters and their ports are absent. The remaining behaviour is identical.

## Test plan
- Reset with all inputs nonzero: after one edge, valid_out = 0, wb_out = 2'b01, and all other outputs = 0.
- Plain load: rdata1_in = 32'hDEADBEEF, imm_in = 32'h000007C0, valid_in = 1 → next edge rdata1_out = 32'hDEADBEEF, shamt_out = 5'd31, valid_out = 1.
- Load-use: EX holds lw (m_out = 2'b10, rt_out = 5'd8); ID presents rs_in = 5'd8 → hazard_stall = 1. Next edge: valid_out = 0 and m_out = 0. Following edge: the ID instruction loads.
- Load-use specifier checks: rt_out = 0 with rs_in = 0 → hazard_stall = 0; also check the rt_in match path (rt_in = 5'd8) → hazard_stall = 1.
- Stall: assert stall for 3 cycles with changing inputs → outputs are constant. Then stall + flush together → bubble.
- With ID_EX_PERF_CNT_EN: two hazard bubbles and one flush → bubble_cnt = 2, flush_cnt = 1. Force bubble_cnt to 32'hFFFFFFFF plus one more hazard → it stays 32'hFFFFFFFF.
